// File: rtl/lsu_ram_master.sv
// Load/store initiator driving a word-only, big-endian RAM data port; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err_o instead of aligning them down.
module lsu_ram_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_we_o,
  output logic        ram_req_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW, S_WR, S_RSP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        uns_q, err_q;
  logic        accept, misalign;
  logic [4:0]  lane_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;

  assign accept = req_valid_i && req_ready_o;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                    (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Big-endian lanes: byte offset k lives at bit (3-k)*8, and 3-k == ~k for two bits.
  assign lane_sh = {~addr_q[1:0], 3'b000};
  assign lane_b  = 8'(ram_data_i >> lane_sh);
  assign lane_h  = addr_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];

  always_comb begin
    load_ext = ram_data_i;
    merged   = wdata_q;
    if (!size_q[1]) begin
      if (size_q[0]) begin
        load_ext = {(uns_q ? 16'h0000 : {16{lane_h[15]}}), lane_h};
        merged   = addr_q[1] ? {ram_data_i[31:16], wdata_q[15:0]}
                             : {wdata_q[15:0], ram_data_i[15:0]};
      end else begin
        load_ext = {(uns_q ? 24'h000000 : {24{lane_b[7]}}), lane_b};
        merged   = (ram_data_i & ~(32'h0000_00FF << lane_sh)) |
                   ({24'h000000, wdata_q[7:0]} << lane_sh);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (misalign)       state_d = S_RSP;
        else if (!req_we_i) state_d = S_RD;
        else if (req_size_i[1]) state_d = S_WR;
        else                state_d = S_RMW;
      end
      S_RD:  state_d = S_RSP;
      S_RMW: state_d = S_WR;
      S_WR:  state_d = S_RSP;
      S_RSP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        rdata_q <= '0;
        err_q   <= misalign;
      end
      if (state_q == S_RD)  rdata_q <= load_ext;
      if (state_q == S_RMW) wdata_q <= merged;
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    ram_addr_o  = '0;
    ram_data_o  = '0;
    ram_we_o    = 1'b0;
    ram_req_o   = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o = rst_ni;
      S_RD, S_RMW: begin
        ram_req_o  = rst_ni;
        ram_addr_o = {addr_q[31:2], 2'b00};
      end
      S_WR: begin
        ram_req_o  = rst_ni;
        ram_we_o   = rst_ni;
        ram_addr_o = {addr_q[31:2], 2'b00};
        ram_data_o = wdata_q;
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed + randomized bench for lsu_ram_master against a byte-array memory model.
module tb_lsu_ram_master;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o, ram_addr_o, ram_data_o, ram_data_i;
  logic        ram_we_o, ram_req_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram_mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] rd;

  always #5 clk = ~clk;

  lsu_ram_master dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_we_o(ram_we_o), .ram_req_o(ram_req_o), .ram_data_i(ram_data_i)
  );

  assign ram_data_i = ram_mem[ram_addr_o[9:2]];
  always @(posedge clk) if (ram_req_o && ram_we_o) ram_mem[ram_addr_o[9:2]] <= ram_data_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: expectation from the byte model, then drive, observe, handshake.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata);
    int nb, idx, lat, reqc, wec, t;
    logic mis, exp_err;
    logic [31:0] ea, wa, val, exp_rd, exp_word, wr_word, rd0;
    int exp_lat, exp_req, exp_we;
    logic addr_bad;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    ea  = addr & ~(32'(nb) - 32'd1);
    wa  = ea & ~32'd3;
    exp_err = 1'b0; exp_rd = '0; exp_word = '0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (mis) begin
      exp_err = 1'b1; exp_lat = 1; exp_req = 0; exp_we = 0;
    end else
`endif
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(ea[9:0]) + i] = wdata[8*(nb-1-i) +: 8];
      for (int i = 0; i < 4; i++) exp_word = {exp_word[23:0], ref_mem[int'(wa[9:0]) + i]};
      exp_lat = (nb == 4) ? 2 : 3; exp_req = (nb == 4) ? 1 : 2; exp_we = 1;
    end else begin
      val = '0;
      for (int i = 0; i < nb; i++) val = (val << 8) | {24'h0, ref_mem[int'(ea[9:0]) + i]};
      if (nb < 4 && !uns && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
      exp_rd = val; exp_lat = 2; exp_req = 1; exp_we = 0;
    end
    if (mis && 1'b0) exp_rd = '0;

    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    t = 0;
    while (!req_ready_o && t < 20) begin @(negedge clk); t++; end
    chk("req_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk);
    lat = 0; reqc = 0; wec = 0; addr_bad = 1'b0; wr_word = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_size_i = 2'($urandom);
        req_unsigned_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
      end
      if (ram_req_o) begin
        reqc++;
        if (ram_addr_o != wa) addr_bad = 1'b1;
      end
      if (ram_we_o) begin wec++; wr_word = ram_data_o; end
    end while (!rsp_valid_o && lat < 10);
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ram_req_cycles", 32'(reqc), 32'(exp_req));
    chk("ram_we_cycles", 32'(wec), 32'(exp_we));
    chk("ram_addr", {31'b0, addr_bad}, 32'd0);
    chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    if (exp_we == 1) chk("ram_wdata", wr_word, exp_word);
    rdata = rsp_rdata_o;
    rd0 = rsp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid_o, req_ready_o, rsp_err_o}, {1'b1, 1'b0, exp_err});
      chk("bp_rdata", rsp_rdata_o, rd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("post_rsp_idle", {30'b0, req_ready_o, rsp_valid_o}, 32'd2);
  endtask

  initial begin
    logic mis_word;
    int t;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {27'b0, req_ready_o, rsp_valid_o, rsp_err_o, ram_we_o, ram_req_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_ram", ram_addr_o | ram_data_o, 32'd0);
    rst_ni = 1'b1;

    for (int w = 0; w < 16; w++) access(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4*w), $urandom, 0, rd);

    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 0, rd);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd);
    chk("word_roundtrip", rd, 32'h11223344);
    access(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, rd);
    chk("byte101_s", rd, 32'h00000022);
    access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000F0, 0, rd);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd);
    chk("word_after_byte", rd, 32'h112233F0);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, rd);
    chk("byte103_s", rd, 32'hFFFFFFF0);
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, rd);
    chk("byte103_u", rd, 32'h000000F0);
    access(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 0, rd);
    access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, rd);
    chk("half102_s", rd, 32'hFFFFBEEF);

    // Misaligned word load, also exercising response backpressure.
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5, rd);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("misalign_rdata", rd, 32'h0);
`else
    chk("misalign_rdata", rd, 32'h1122BEEF);
`endif

    // Reset during the write phase of a byte store.
    access(1'b1, 2'd2, 1'b0, 32'h200, 32'h12345678, 0, rd);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = 32'h200; req_wdata_i = 32'h000000AA;
    chk("rmid_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk);
    t = 0;
    do begin
      @(negedge clk);
      req_valid_i = 1'b0;
      t++;
    end while (!ram_we_o && t < 6);
    chk("rmid_in_wr", {31'b0, ram_we_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rmid_gate", {30'b0, ram_we_o, ram_req_o}, 32'd0);
    @(negedge clk);
    chk("rmid_ctl", {27'b0, req_ready_o, rsp_valid_o, rsp_err_o, ram_we_o, ram_req_o}, 32'd0);
    chk("rmid_data", rsp_rdata_o | ram_addr_o | ram_data_o, 32'd0);
    rst_ni = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, rd);
    chk("rmid_old", rd, 32'h12345678);

    for (int i = 0; i < 80; i++) begin
      mis_word = 1'($urandom);
      access(1'($urandom), 2'($urandom), 1'($urandom),
             32'h100 + 32'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 2)), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
